// File: rtl/stack_up_arbiter.sv
// stack_up_arbiter
//   Merges NUM_SRC framed upstream beat streams onto one registered stack bus.
//   Messages are never interleaved: once a source opens a message (SOM) it
//   keeps the bus until its EOM. Between messages, sources are served
//   round-robin starting after the last source that completed a message.
//
// Ports
//   clk, reset_poll          : clock, synchronous active-high reset
//   src__arb__valid/cntl/... : per-source beat (cntl 00 MOM, 01 SOM, 10 EOM, 11 SOM_EOM)
//   arb__src__ready          : per-source accept (one-hot or zero)
//   arb__stu__*              : registered output beat plus its source index
//   stu__arb__ready          : downstream accept
//   arb__sys__err            : sticky per-source framing error
//   arb__sys__msg_count      : wrapping count of forwarded end-of-message beats
module stack_up_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int TYPE_W  = 2,
    parameter int OOB_W   = 32,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_poll,
    input  logic [NUM_SRC-1:0]        src__arb__valid,
    input  logic [2*NUM_SRC-1:0]      src__arb__cntl,
    input  logic [TYPE_W*NUM_SRC-1:0] src__arb__type,
    input  logic [DATA_W*NUM_SRC-1:0] src__arb__data,
    input  logic [OOB_W*NUM_SRC-1:0]  src__arb__oob_data,
    output logic [NUM_SRC-1:0]        arb__src__ready,
    output logic                      arb__stu__valid,
    output logic [1:0]                arb__stu__cntl,
    output logic [TYPE_W-1:0]         arb__stu__type,
    output logic [DATA_W-1:0]         arb__stu__data,
    output logic [OOB_W-1:0]          arb__stu__oob_data,
    input  logic                      stu__arb__ready,
    output logic [SRC_W-1:0]          arb__stu__src,
    output logic [NUM_SRC-1:0]        arb__sys__err,
    output logic [15:0]               arb__sys__msg_count
);

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   last_src_q, last_src_d;
    logic [SRC_W-1:0]   lock_src_q, lock_src_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_cntl_q, out_cntl_d;
    logic [TYPE_W-1:0]  out_type_q, out_type_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [OOB_W-1:0]   out_oob_q, out_oob_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [NUM_SRC-1:0] err_q, err_d;
    logic [15:0]        msg_count_q, msg_count_d;

    logic               out_free;
    logic               found_hi, found_lo;
    logic [SRC_W-1:0]   idx_hi, idx_lo;
    logic [SRC_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [1:0]         sel_cntl;
    logic [TYPE_W-1:0]  sel_type;
    logic [DATA_W-1:0]  sel_data;
    logic [OOB_W-1:0]   sel_oob;
    logic               grant;
    logic               forward;
    logic               err_set;

    always_comb begin
        out_free = !out_valid_q || stu__arb__ready;

        // Round-robin winner: lowest valid index above last_src, otherwise
        // wrap to the lowest valid index overall (which may be last_src).
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (src__arb__valid[s]) begin
                if (!found_hi && (SRC_W'(s) > last_src_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = SRC_W'(s);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = SRC_W'(s);
                end
            end
        end

        sel_idx = (state_q == ST_LOCKED) ? lock_src_q : (found_hi ? idx_hi : idx_lo);

        sel_valid = 1'b0;
        sel_cntl  = '0;
        sel_type  = '0;
        sel_data  = '0;
        sel_oob   = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (SRC_W'(s) == sel_idx) begin
                sel_valid = src__arb__valid[s];
                sel_cntl  = src__arb__cntl[2*s +: 2];
                sel_type  = src__arb__type[TYPE_W*s +: TYPE_W];
                sel_data  = src__arb__data[DATA_W*s +: DATA_W];
                sel_oob   = src__arb__oob_data[OOB_W*s +: OOB_W];
            end
        end

        grant = sel_valid && out_free && !reset_poll;

        arb__src__ready = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            arb__src__ready[s] = grant && (SRC_W'(s) == sel_idx);
        end

        state_d    = state_q;
        last_src_d = last_src_q;
        lock_src_d = lock_src_q;
        forward    = 1'b0;
        err_set    = 1'b0;

        if (grant) begin
            if (state_q == ST_IDLE) begin
                case (sel_cntl)
                    CNTL_SOM: begin
                        forward    = 1'b1;
                        state_d    = ST_LOCKED;
                        lock_src_d = sel_idx;
                    end
                    CNTL_SOM_EOM: begin
                        forward    = 1'b1;
                        last_src_d = sel_idx;
                    end
                    // Orphan MOM/EOM: swallowed so the source cannot stall the bus.
                    default: begin
                        err_set = 1'b1;
                    end
                endcase
            end else begin
                // Everything from the owner is forwarded; a nested SOM is a
                // framing error but its EOM bit still decides whether we close.
                forward = 1'b1;
                if (sel_cntl[0]) begin
                    err_set = 1'b1;
                end
                if (sel_cntl[1]) begin
                    state_d    = ST_IDLE;
                    last_src_d = lock_src_q;
                end
            end
        end

        // ready is one-hot on the granted source, so it doubles as the error mask.
        err_d = err_q | (err_set ? arb__src__ready : '0);

        out_valid_d = out_valid_q;
        out_cntl_d  = out_cntl_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
        out_oob_d   = out_oob_q;
        out_src_d   = out_src_q;
        if (forward) begin
            out_valid_d = 1'b1;
            out_cntl_d  = sel_cntl;
            out_type_d  = sel_type;
            out_data_d  = sel_data;
            out_oob_d   = sel_oob;
            out_src_d   = sel_idx;
        end else if (stu__arb__ready) begin
            out_valid_d = 1'b0;
        end

        msg_count_d = msg_count_q;
        if (forward && sel_cntl[1]) begin
            msg_count_d = msg_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poll) begin
            state_q     <= ST_IDLE;
            last_src_q  <= SRC_W'(NUM_SRC - 1);
            lock_src_q  <= '0;
            out_valid_q <= 1'b0;
            out_cntl_q  <= '0;
            out_type_q  <= '0;
            out_data_q  <= '0;
            out_oob_q   <= '0;
            out_src_q   <= '0;
            err_q       <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_src_q  <= last_src_d;
            lock_src_q  <= lock_src_d;
            out_valid_q <= out_valid_d;
            out_cntl_q  <= out_cntl_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
            out_oob_q   <= out_oob_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
            msg_count_q <= msg_count_d;
        end
    end

    assign arb__stu__valid     = out_valid_q;
    assign arb__stu__cntl      = out_cntl_q;
    assign arb__stu__type      = out_type_q;
    assign arb__stu__data      = out_data_q;
    assign arb__stu__oob_data  = out_oob_q;
    assign arb__stu__src       = out_src_q;
    assign arb__sys__err       = err_q;
    assign arb__sys__msg_count = msg_count_q;

endmodule

// File: tb/tb_stack_up_arbiter.sv
// tb_stack_up_arbiter
//   Directed scenarios for the arbiter's framing rules followed by a random
//   session: per-source message queues are played into the DUT with random
//   downstream back-pressure and the forwarded stream is scored against a
//   message-level round-robin model built from the same queues.
module tb_stack_up_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int TW = 2;
    localparam int OW = 32;
    localparam int SW = 2;

    localparam logic [1:0] MOM = 2'b00;
    localparam logic [1:0] SOM = 2'b01;
    localparam logic [1:0] EOM = 2'b10;
    localparam logic [1:0] SE  = 2'b11;

    logic             clk = 1'b0;
    logic             reset_poll;
    logic [NS-1:0]    valid;
    logic [2*NS-1:0]  cntl;
    logic [TW*NS-1:0] typ;
    logic [DW*NS-1:0] data;
    logic [OW*NS-1:0] oob;
    logic [NS-1:0]    ready;
    logic             o_valid;
    logic [1:0]       o_cntl;
    logic [TW-1:0]    o_type;
    logic [DW-1:0]    o_data;
    logic [OW-1:0]    o_oob;
    logic             stu_ready;
    logic [SW-1:0]    o_src;
    logic [NS-1:0]    err;
    logic [15:0]      msg_count;

    int checks = 0;
    int failures = 0;

    stack_up_arbiter #(
        .NUM_SRC(NS),
        .DATA_W (DW),
        .TYPE_W (TW),
        .OOB_W  (OW)
    ) dut (
        .clk                (clk),
        .reset_poll         (reset_poll),
        .src__arb__valid    (valid),
        .src__arb__cntl     (cntl),
        .src__arb__type     (typ),
        .src__arb__data     (data),
        .src__arb__oob_data (oob),
        .arb__src__ready    (ready),
        .arb__stu__valid    (o_valid),
        .arb__stu__cntl     (o_cntl),
        .arb__stu__type     (o_type),
        .arb__stu__data     (o_data),
        .arb__stu__oob_data (o_oob),
        .stu__arb__ready    (stu_ready),
        .arb__stu__src      (o_src),
        .arb__sys__err      (err),
        .arb__sys__msg_count(msg_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] c; int n; } beat_t;
    typedef struct { int s; logic [1:0] c; int n; } obeat_t;

    beat_t  srcq[NS][$];
    beat_t  mq[NS][$];
    obeat_t expq[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(int s, int n);
        return {8'hD0, 24'(s), 32'(n)};
    endfunction

    function automatic logic [31:0] mk_oob(int s, int n);
        return 32'hB000_0000 ^ (32'(s) << 16) ^ 32'(n);
    endfunction

    function automatic logic [127:0] beat_vec(int s, logic [1:0] c, int n);
        return 128'({SW'(s), c, TW'(n), mk_data(s, n), mk_oob(s, n)});
    endfunction

    function automatic logic [127:0] out_vec();
        return 128'({o_src, o_cntl, o_type, o_data, o_oob});
    endfunction

    task automatic put(input int s, input logic [1:0] c, input int n);
        valid[s]          = 1'b1;
        cntl[2*s +: 2]    = c;
        typ[TW*s +: TW]   = TW'(n);
        data[DW*s +: DW]  = mk_data(s, n);
        oob[OW*s +: OW]   = mk_oob(s, n);
    endtask

    task automatic drop(input int s);
        valid[s] = 1'b0;
    endtask

    task automatic clr();
        valid = '0;
        cntl  = '0;
        typ   = '0;
        data  = '0;
        oob   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges with every source offering a beat; ready must stay low.
    task automatic do_reset();
        reset_poll = 1'b1;
        stu_ready  = 1'b1;
        clr();
        for (int s = 0; s < NS; s++) put(s, SE, 50 + s);
        tick();
        #1;
        chk("reset_ready_low", 128'(ready), 128'(0));
        tick();
        reset_poll = 1'b0;
        clr();
    endtask

    function automatic int pending();
        int t = 0;
        for (int s = 0; s < NS; s++) t += srcq[s].size();
        return t;
    endfunction

    function automatic int mpending();
        int t = 0;
        for (int s = 0; s < NS; s++) t += mq[s].size();
        return t;
    endfunction

    initial begin
        logic [1:0] seq2 [4];
        logic [1:0] seq3 [3];
        logic [3:0] merr;
        int         mmsg;
        int         last;
        int         ls;
        bit         locked;
        int         w;
        int         cyc;
        beat_t      b;
        obeat_t     e;
        logic [127:0] expv;

        reset_poll = 1'b1;
        stu_ready  = 1'b1;
        clr();

        // Reset state.
        do_reset();
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_out", out_vec(), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_msg", 128'(msg_count), 128'(0));

        // Four simultaneous single-beat messages: granted 0,1,2,3.
        for (int k = 0; k < NS; k++) put(k, SE, k);
        for (int k = 0; k < NS; k++) begin
            #1;
            chk("rr_ready", 128'(ready), 128'(4'b0001 << k));
            tick();
            drop(k);
            chk("rr_valid", 128'(o_valid), 128'(1));
            chk("rr_beat", out_vec(), beat_vec(k, SE, k));
        end
        chk("rr_msg", 128'(msg_count), 128'(16'd4));
        tick();
        chk("rr_drain", 128'(o_valid), 128'(0));

        // Source 2 keeps the bus for its whole message while source 0 waits.
        do_reset();
        seq2[0] = SOM; seq2[1] = MOM; seq2[2] = MOM; seq2[3] = EOM;
        for (int i = 0; i < 4; i++) begin
            put(2, seq2[i], i);
            if (i == 1) put(0, SE, 9);
            #1;
            chk("lock_ready", 128'(ready), 128'(4'b0100));
            tick();
            chk("lock_beat", out_vec(), beat_vec(2, seq2[i], i));
        end
        drop(2);
        #1;
        chk("lock_next_ready", 128'(ready), 128'(4'b0001));
        tick();
        drop(0);
        chk("lock_next_beat", out_vec(), beat_vec(0, SE, 9));

        // Downstream stall mid-message.
        do_reset();
        put(1, SOM, 0);
        #1;
        chk("stall_som_ready", 128'(ready), 128'(4'b0010));
        tick();
        chk("stall_som", out_vec(), beat_vec(1, SOM, 0));
        put(1, MOM, 1);
        tick();
        chk("stall_m1", out_vec(), beat_vec(1, MOM, 1));
        put(1, MOM, 2);
        stu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready_low", 128'(ready), 128'(0));
            tick();
            chk("stall_hold", out_vec(), beat_vec(1, MOM, 1));
            chk("stall_hold_valid", 128'(o_valid), 128'(1));
        end
        stu_ready = 1'b1;
        #1;
        chk("stall_resume_ready", 128'(ready), 128'(4'b0010));
        tick();
        chk("stall_m2", out_vec(), beat_vec(1, MOM, 2));
        put(1, EOM, 3);
        tick();
        drop(1);
        chk("stall_eom", out_vec(), beat_vec(1, EOM, 3));
        chk("stall_msg", 128'(msg_count), 128'(16'd1));

        // Orphan EOM while idle is swallowed and flagged.
        do_reset();
        put(1, EOM, 0);
        #1;
        chk("orphan_ready", 128'(ready), 128'(4'b0010));
        tick();
        drop(1);
        chk("orphan_not_fwd", 128'(o_valid), 128'(0));
        chk("orphan_err", 128'(err), 128'(4'b0010));
        chk("orphan_msg", 128'(msg_count), 128'(0));

        // Nested SOM is forwarded and flagged; message still closes on EOM.
        do_reset();
        seq3[0] = SOM; seq3[1] = SOM; seq3[2] = EOM;
        for (int i = 0; i < 3; i++) begin
            put(3, seq3[i], i);
            #1;
            chk("nest_ready", 128'(ready), 128'(4'b1000));
            tick();
            chk("nest_beat", out_vec(), beat_vec(3, seq3[i], i));
        end
        drop(3);
        chk("nest_err", 128'(err), 128'(4'b1000));
        put(0, SE, 5);
        #1;
        chk("nest_idle_ready", 128'(ready), 128'(4'b0001));
        tick();
        drop(0);
        chk("nest_idle_beat", out_vec(), beat_vec(0, SE, 5));
        chk("nest_msg", 128'(msg_count), 128'(16'd2));

        // Reset in the middle of an open message.
        do_reset();
        put(1, SOM, 0);
        tick();
        chk("mid_rst_som", out_vec(), beat_vec(1, SOM, 0));
        put(1, MOM, 1);
        reset_poll = 1'b1;
        #1;
        chk("mid_rst_ready", 128'(ready), 128'(0));
        tick();
        reset_poll = 1'b0;
        drop(1);
        chk("mid_rst_valid", 128'(o_valid), 128'(0));
        chk("mid_rst_out", out_vec(), 128'(0));
        chk("mid_rst_err", 128'(err), 128'(0));
        put(0, SE, 7);
        #1;
        chk("mid_rst_new_ready", 128'(ready), 128'(4'b0001));
        tick();
        drop(0);
        chk("mid_rst_new_beat", out_vec(), beat_vec(0, SE, 7));
        chk("mid_rst_msg", 128'(msg_count), 128'(16'd1));
        chk("mid_rst_err2", 128'(err), 128'(0));

        // Random session: build per-source beat queues.
        for (int s = 0; s < NS; s++) begin
            int n = 100;
            int nm = $urandom_range(1, 4);
            for (int m = 0; m < nm; m++) begin
                int r = $urandom_range(0, 7);
                if (r == 0) begin
                    srcq[s].push_back('{($urandom_range(0, 1) != 0) ? MOM : EOM, n}); n++;
                end else if (r <= 2) begin
                    srcq[s].push_back('{SE, n}); n++;
                end else begin
                    int k = $urandom_range(0, 3);
                    srcq[s].push_back('{SOM, n}); n++;
                    for (int j = 0; j < k; j++) begin
                        srcq[s].push_back('{($urandom_range(0, 7) == 0) ? SOM : MOM, n}); n++;
                    end
                    srcq[s].push_back('{EOM, n}); n++;
                end
            end
            mq[s] = srcq[s];
        end

        // Message-level model: every non-empty queue is a valid source.
        merr = '0; mmsg = 0; last = NS - 1; locked = 0; ls = 0;
        while (mpending() > 0) begin
            if (!locked) begin
                w = -1;
                for (int i = 1; i <= NS; i++) begin
                    if (w < 0 && mq[(last + i) % NS].size() > 0) w = (last + i) % NS;
                end
                b = mq[w].pop_front();
                if (b.c == SOM) begin
                    expq.push_back('{w, b.c, b.n}); locked = 1; ls = w;
                end else if (b.c == SE) begin
                    expq.push_back('{w, b.c, b.n}); mmsg++; last = w;
                end else begin
                    merr[w] = 1'b1;
                end
            end else begin
                if (mq[ls].size() == 0) break;
                b = mq[ls].pop_front();
                expq.push_back('{ls, b.c, b.n});
                if (b.c[0]) merr[ls] = 1'b1;
                if (b.c[1]) begin
                    mmsg++; last = ls; locked = 0;
                end
            end
        end

        do_reset();
        cyc = 0;
        while ((pending() > 0 || expq.size() > 0) && cyc < 2000) begin
            for (int s = 0; s < NS; s++) begin
                if (srcq[s].size() > 0) put(s, srcq[s][0].c, srcq[s][0].n);
                else drop(s);
            end
            stu_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_onehot", 128'($onehot0(ready)), 128'(1));
            if (o_valid && !stu_ready) chk("rnd_stall_ready", 128'(ready), 128'(0));
            if (o_valid && stu_ready) begin
                expv = '1;
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    expv = beat_vec(e.s, e.c, e.n);
                end
                chk("rnd_beat", out_vec(), expv);
            end
            for (int s = 0; s < NS; s++) begin
                if (valid[s] && ready[s]) void'(srcq[s].pop_front());
            end
            tick();
            cyc++;
        end
        clr();
        chk("rnd_drained", 128'(pending() + expq.size()), 128'(0));
        chk("rnd_err", 128'(err), 128'(merr));
        chk("rnd_msg", 128'(msg_count), 128'(16'(mmsg)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
